// File: rtl/shift_add_multiplier.sv
// rtl/shift_add_multiplier.sv - sequential unsigned N x N -> 2N shift-add multiplier
//
// One add/shift step per multiplier bit through a single shared N-bit adder.
// Ports:
//   clk          in   1    clock, all state updates on rising edge
//   rst_n        in   1    synchronous active-low reset
//   start_valid  in   1    operands a/b valid
//   start_ready  out  1    idle, operands accepted on start_valid
//   a            in   N    multiplicand (unsigned)
//   b            in   N    multiplier (unsigned)
//   prod_valid   out  1    prod holds a finished result
//   prod_ready   in   1    consumer accepts prod
//   prod         out  2N   unsigned product a*b
//   busy         out  1    high while computing or holding a result
module shift_add_multiplier #(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start_valid,
  output logic           start_ready,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           prod_valid,
  input  logic           prod_ready,
  output logic [2*N-1:0] prod,
  output logic           busy
);

  localparam int CW = $clog2(N) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [N-1:0]  mcand;
  logic [N-1:0]  acc;
  logic [N-1:0]  mplier;
  logic [CW-1:0] count;

  logic [N-1:0]  addend;
  logic [N:0]    sum_c;   // {carry, sum} of the shared adder
  logic          last_step;

  assign addend    = mplier[0] ? mcand : '0;
  assign sum_c     = {1'b0, acc} + {1'b0, addend};
  assign last_step = (count == CW'(N - 1));

  assign prod = {acc, mplier};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      mcand  <= '0;
      acc    <= '0;
      mplier <= '0;
      count  <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (start_valid) begin
            mcand  <= a;
            mplier <= b;
            acc    <= '0;
            count  <= '0;
          end
        end
        RUN: begin
          // The carry lands in the acc MSB so no bit of the partial product is lost.
          {acc, mplier} <= {sum_c, mplier[N-1:1]};
          count         <= count + 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  always_comb begin
    state_nxt   = state;
    start_ready = 1'b0;
    prod_valid  = 1'b0;
    busy        = 1'b0;
    case (state)
      IDLE: begin
        start_ready = 1'b1;
        if (start_valid) state_nxt = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last_step) state_nxt = DONE;
      end
      DONE: begin
        busy       = 1'b1;
        prod_valid = 1'b1;
        if (prod_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_shift_add_multiplier.sv
// tb/tb_shift_add_multiplier.sv - randomized self-checking bench for shift_add_multiplier
module tb_shift_add_multiplier;

  localparam int N = 8;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           start_valid;
  logic           start_ready;
  logic [N-1:0]   a;
  logic [N-1:0]   b;
  logic           prod_valid;
  logic           prod_ready;
  logic [2*N-1:0] prod;
  logic           busy;

  int checks = 0;
  int errors = 0;

  shift_add_multiplier #(.N(N)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .a           (a),
    .b           (b),
    .prod_valid  (prod_valid),
    .prod_ready  (prod_ready),
    .prod        (prod),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: product is plain unsigned arithmetic a*b; latency is N edges.
  task automatic run_op(input logic [N-1:0] ta, input logic [N-1:0] tb_v,
                        input int stall, input bit poke);
    logic [2*N-1:0] exp_p;
    int lat;
    exp_p = {{N{1'b0}}, ta} * {{N{1'b0}}, tb_v};
    @(negedge clk);
    check("idle_start_ready", start_ready, 1);
    start_valid = 1'b1;
    a           = ta;
    b           = tb_v;
    prod_ready  = (stall == 0);
    @(negedge clk);
    start_valid = 1'b0;
    a   = N'($urandom);
    b   = N'($urandom);
    lat = 0;
    while (!prod_valid && lat < 4 * N) begin
      check("run_start_ready", start_ready, 0);
      check("run_busy", busy, 1);
      start_valid = poke ? 1'($urandom) : 1'b0;
      @(negedge clk);
      lat++;
    end
    check("latency", lat, N);
    check("prod", prod, exp_p);
    check("done_busy", busy, 1);
    check("done_start_ready", start_ready, 0);
    for (int i = 0; i < stall; i++) begin
      start_valid = poke ? 1'b1 : 1'b0;
      a = N'($urandom);
      b = N'($urandom);
      @(negedge clk);
      check("stall_valid", prod_valid, 1);
      check("stall_prod", prod, exp_p);
    end
    start_valid = 1'b0;
    prod_ready  = 1'b1;
    @(negedge clk);
    check("post_valid", prod_valid, 0);
    check("post_start_ready", start_ready, 1);
    check("post_busy", busy, 0);
  endtask

  initial begin
    rst_n       = 1'b0;
    start_valid = 1'b0;
    prod_ready  = 1'b1;
    a           = '0;
    b           = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_start_ready", start_ready, 1);
    check("rst_prod_valid", prod_valid, 0);
    check("rst_prod", prod, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;

    run_op(8'd5, 8'd1, 0, 1'b0);
    run_op(8'd255, 8'd255, 0, 1'b0);
    run_op(8'd0, 8'd200, 0, 1'b1);
    run_op(8'd40, 8'd6, 0, 1'b1);
    run_op(8'd10, 8'd2, 5, 1'b1);
    run_op(8'd255, 8'd0, 2, 1'b0);
    run_op(8'd1, 8'd255, 1, 1'b0);

    // Reset during RUN discards the partial result.
    @(negedge clk);
    start_valid = 1'b1;
    a = 8'd25;
    b = 8'd5;
    @(negedge clk);
    start_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("mid_busy", busy, 1);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_start_ready", start_ready, 1);
    check("mid_rst_prod", prod, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_valid", prod_valid, 0);
    rst_n = 1'b1;
    run_op(8'd15, 8'd3, 0, 1'b0);

    // Reset while holding a result in DONE.
    @(negedge clk);
    start_valid = 1'b1;
    a = 8'd7;
    b = 8'd9;
    prod_ready = 1'b0;
    @(negedge clk);
    start_valid = 1'b0;
    repeat (N + 1) @(negedge clk);
    check("hold_valid", prod_valid, 1);
    check("hold_prod", prod, 63);
    rst_n = 1'b0;
    @(negedge clk);
    check("done_rst_valid", prod_valid, 0);
    check("done_rst_prod", prod, 0);
    rst_n = 1'b1;
    prod_ready = 1'b1;

    for (int k = 0; k < 25; k++) begin
      run_op(N'($urandom), N'($urandom), int'($urandom_range(0, 3)), 1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
